control_fsm: RTL and testbench

Multicycle control unit for the RV core. It decodes the instruction-register fields (opcode, funct3, funct7) and sequences the shared datapath across fetch, decode, execute, memory and writeback, one step per clock. It drives every datapath strobe and mux select, and handshakes with the unified instruction/data memory port via `mem_req`/`mem_ready`.

---
 rtl/control_fsm.sv | 223 ++++++++++++++++++++++
 tb/tb_control_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback
// for the shared datapath and handshakes with the unified memory port.
module control_fsm #(
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic [6:0]         funct7,
   input  logic               alu_zero,
   input  logic               alu_lt,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_sel,
   output logic               reg_write,
   output logic [1:0]         wb_sel,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [3:0]         alu_op,
   output logic               halted,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WB   = 4'd7,
      S_MEM_WR   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_WB_ALU   = 4'd13,
      S_HALT     = 4'd14
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_SLL = 4'd2;
   localparam logic [3:0] ALU_SLT = 4'd3;
   localparam logic [3:0] ALU_SRL = 4'd4;
   localparam logic [3:0] ALU_SRA = 4'd5;
   localparam logic [3:0] ALU_AND = 4'd6;

   state_t r_state;
   state_t w_next;
   logic   r_started;
   logic   r_illegal;
   logic   w_bad_op;
   logic   w_alt_r;
   logic   w_alt_i;
   logic   w_taken;

   function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  f_alu_op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  f_alu_op = ALU_SLL;
         3'b010:  f_alu_op = ALU_SLT;
         3'b101:  f_alu_op = alt ? ALU_SRA : ALU_SRL;
         3'b111:  f_alu_op = ALU_AND;
         default: f_alu_op = ALU_ADD;
      endcase
   endfunction

   assign w_alt_r = (funct7 == 7'b0100000);
   assign w_alt_i = (funct3 == 3'b101) && w_alt_r;

   always_comb begin
      case (funct3)
         3'b000:  w_taken = alu_zero;
         3'b001:  w_taken = !alu_zero;
         3'b100:  w_taken = alu_lt;
         3'b101:  w_taken = !alu_lt;
         default: w_taken = 1'b0;
      endcase
   end

   // r_started holds IDLE for one extra edge so the first FETCH lands on
   // the second rising edge after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_started <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_started <= 1'b1;
         if (r_state == S_DECODE && w_bad_op)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_bad_op = 1'b0;
      case (r_state)
         S_IDLE:     w_next = r_started ? S_FETCH : S_IDLE;
         S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_R:               w_next = S_EXEC_R;
               OP_I:               w_next = S_EXEC_I;
               OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
               OP_BRANCH:          w_next = S_BRANCH;
               OP_JAL:             w_next = S_JAL;
               OP_JALR:            w_next = S_JALR;
               OP_LUI:             w_next = S_LUI;
               OP_SYSTEM:          w_next = S_HALT;
               default: begin
                  w_next   = S_HALT;
                  w_bad_op = 1'b1;
               end
            endcase
         end
         S_EXEC_R, S_EXEC_I:  w_next = S_WB_ALU;
         S_MEM_ADDR: w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
         S_MEM_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_WB_ALU: w_next = S_FETCH;
         S_HALT:     w_next = S_HALT;
         default:    w_next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_sel    = 2'd0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      alu_src_a = 2'd0;
      alu_src_b = 2'd0;
      alu_op    = ALU_ADD;
      halted    = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd2;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
         end
         S_EXEC_R: begin
            alu_src_a = 2'd2;
            alu_op    = f_alu_op(funct3, w_alt_r);
         end
         S_EXEC_I: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            alu_op    = f_alu_op(funct3, w_alt_i);
         end
         S_WB_ALU:   reg_write = 1'b1;
         S_MEM_ADDR: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
         end
         S_MEM_RD:   mem_req = 1'b1;
         S_MEM_WB: begin
            reg_write = 1'b1;
            wb_sel    = 2'd1;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 2'd2;
            alu_op    = ALU_SUB;
            pc_write  = w_taken;
            pc_sel    = 2'd1;
         end
         S_JAL: begin
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            pc_write  = 1'b1;
            pc_sel    = 2'd1;
         end
         S_JALR: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            pc_write  = 1'b1;
            pc_sel    = 2'd2;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
         end
         S_LUI: begin
            reg_write = 1'b1;
            wb_sel    = 2'd3;
         end
         S_HALT:     halted = 1'b1;
         default: ;
      endcase
   end

   assign illegal = r_illegal;
   assign state   = STATE_W'(r_state);

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks one instruction of each class
// through the sequencer and checks state and strobes cycle by cycle.
module tb_control_fsm;

   logic        clk;
   logic        reset_n;
   logic [31:0] instr;
   logic        alu_zero;
   logic        alu_lt;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        ir_write;
   logic        pc_write;
   logic [1:0]  pc_sel;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [3:0]  alu_op;
   logic        halted;
   logic        illegal;
   logic [3:0]  state;

   int n_tests = 0;
   int n_fail  = 0;

   control_fsm #(.STATE_W(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .opcode    (instr[6:0]),
      .funct3    (instr[14:12]),
      .funct7    (instr[31:25]),
      .alu_zero  (alu_zero),
      .alu_lt    (alu_lt),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .ir_write  (ir_write),
      .pc_write  (pc_write),
      .pc_sel    (pc_sel),
      .reg_write (reg_write),
      .wb_sel    (wb_sel),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .alu_op    (alu_op),
      .halted    (halted),
      .illegal   (illegal),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {mem_req, mem_we, ir_write, pc_write, reg_write}
   function automatic logic [4:0] strobes();
      return {mem_req, mem_we, ir_write, pc_write, reg_write};
   endfunction

   initial begin
      reset_n   = 1'b0;
      instr     = '0;
      alu_zero  = 1'b0;
      alu_lt    = 1'b0;
      mem_ready = 1'b0;

      tick(); tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_strobes", 32'(strobes()), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      reset_n   = 1'b1;
      mem_ready = 1'b1;
      tick();
      chk("post_rst_idle", 32'(state), 32'd0);
      tick();
      chk("first_fetch", 32'(state), 32'd1);
      chk("fetch_strobes", 32'(strobes()), 32'b10110);
      chk("fetch_srcb", 32'(alu_src_b), 32'd2);
      chk("fetch_pcsel", 32'(pc_sel), 32'd0);

      // ADDI x1,x0,5
      instr = 32'h00500093;
      tick();
      chk("addi_decode", 32'(state), 32'd2);
      chk("decode_src", 32'({alu_src_a, alu_src_b}), 32'b0101);
      chk("decode_rw", 32'(reg_write), 32'd0);
      tick();
      chk("addi_exec", 32'(state), 32'd4);
      chk("addi_op", 32'(alu_op), 32'd0);
      chk("addi_src", 32'({alu_src_a, alu_src_b}), 32'b1001);
      chk("addi_exec_rw", 32'(reg_write), 32'd0);
      tick();
      chk("addi_wb", 32'(state), 32'd13);
      chk("addi_wb_rw", 32'({reg_write, wb_sel}), 32'b100);
      tick();
      chk("addi_fetch", 32'(state), 32'd1);
      chk("addi_fetch_rw", 32'(reg_write), 32'd0);

      // SUB x3,x1,x2
      instr = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
      tick(); tick();
      chk("sub_exec", 32'(state), 32'd3);
      chk("sub_op", 32'(alu_op), 32'd1);
      chk("sub_src", 32'({alu_src_a, alu_src_b}), 32'b1000);
      tick(); tick();
      chk("sub_fetch", 32'(state), 32'd1);

      // SRAI x1,x1,3
      instr = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd1, 7'b0010011};
      tick(); tick();
      chk("srai_exec", 32'(state), 32'd4);
      chk("srai_op", 32'(alu_op), 32'd5);
      tick(); tick();

      // LW x5,8(x1) with three wait cycles
      instr = {12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011};
      tick(); tick();
      chk("lw_addr", 32'(state), 32'd5);
      chk("lw_addr_src", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1001_0000);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lw_wait_state", 32'(state), 32'd6);
         chk("lw_wait_req", 32'({mem_req, mem_we}), 32'b10);
      end
      mem_ready = 1'b1;
      #1;
      chk("lw_ready_req", 32'({mem_req, mem_we}), 32'b10);
      tick();
      chk("lw_memwb", 32'(state), 32'd7);
      chk("lw_memwb_sel", 32'({reg_write, wb_sel, mem_req}), 32'b1010);
      tick();
      chk("lw_fetch", 32'(state), 32'd1);

      // SW x2,4(x1)
      instr = {7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011};
      tick(); tick();
      chk("sw_addr", 32'(state), 32'd5);
      tick();
      chk("sw_memwr", 32'(state), 32'd8);
      chk("sw_req", 32'({mem_req, mem_we, reg_write}), 32'b110);
      tick();
      chk("sw_fetch", 32'(state), 32'd1);

      // BNE with alu_zero=1: not taken
      alu_zero = 1'b1;
      instr = {7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011};
      tick(); tick();
      chk("bne_state", 32'(state), 32'd9);
      chk("bne_pcw", 32'(pc_write), 32'd0);
      chk("bne_op", 32'({alu_op, alu_src_a, alu_src_b}), 32'b0001_10_00);
      tick();

      // BEQ with alu_zero=1: taken
      instr = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011};
      tick(); tick();
      chk("beq_pcw", 32'({pc_write, pc_sel}), 32'b101);
      tick();

      // BGE with alu_lt=0: taken, then alu_lt=1: not taken
      alu_zero = 1'b0;
      instr = {7'd0, 5'd2, 5'd1, 3'b101, 5'd8, 7'b1100011};
      tick(); tick();
      chk("bge_taken", 32'(pc_write), 32'd1);
      alu_lt = 1'b1;
      #1;
      chk("bge_not_taken", 32'(pc_write), 32'd0);
      alu_lt = 1'b0;
      tick();
      chk("br_fetch", 32'(state), 32'd1);

      // JAL
      instr = {20'd16, 5'd1, 7'b1101111};
      tick(); tick();
      chk("jal_state", 32'(state), 32'd10);
      chk("jal_out", 32'({reg_write, wb_sel, pc_write, pc_sel}), 32'b110101);
      tick();

      // JALR x1,0(x1)
      instr = {12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111};
      tick(); tick();
      chk("jalr_state", 32'(state), 32'd11);
      chk("jalr_out", 32'({reg_write, wb_sel, pc_write, pc_sel, alu_src_a, alu_src_b}), 32'b110_110_10_01);
      tick();

      // LUI
      instr = {20'hABCDE, 5'd7, 7'b0110111};
      tick(); tick();
      chk("lui_state", 32'(state), 32'd12);
      chk("lui_out", 32'({reg_write, wb_sel, pc_write}), 32'b1110);
      tick();
      chk("lui_fetch", 32'(state), 32'd1);

      // Reset asserted mid-store while memory is stalled
      instr = {7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011};
      tick(); tick();
      mem_ready = 1'b0;
      tick();
      chk("sw2_memwr", 32'({state, mem_req, mem_we}), 32'b1000_11);
      reset_n = 1'b0;
      #1;
      chk("midstore_rst", 32'({state, 5'(strobes())}), 32'd0);
      tick();
      chk("midstore_hold", 32'({state, 5'(strobes())}), 32'd0);
      reset_n   = 1'b1;
      mem_ready = 1'b1;
      tick();
      chk("rel_idle", 32'(state), 32'd0);
      tick();
      chk("rel_fetch", 32'(state), 32'd1);

      // ECALL/EBREAK opcode: clean halt
      instr = 32'h00000073;
      tick(); tick();
      chk("ecall_halt", 32'({state, halted, illegal}), 32'b1110_10);
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      tick(); tick();
      chk("ecall_refetch", 32'(state), 32'd1);

      // Unsupported opcode: sticky illegal halt
      instr = 32'h0000007F;
      tick();
      chk("bad_decode_ill", 32'(illegal), 32'd0);
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("bad_halt", 32'({state, halted, illegal}), 32'b1110_11);
         chk("bad_strobes", 32'(strobes()), 32'd0);
         tick();
      end
      reset_n = 1'b0;
      #1;
      chk("ill_clear", 32'({state, illegal, halted}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
